// File: rtl/hba_slave_timer_pkg.sv
// Shared HBA definitions: bus FSM encoding, timer register map and CTRL/STATUS bit layout.
package hba_slave_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_ACK           = 2'd1,
        ST_WAIT_DESELECT = 2'd2
    } hba_state_t;

    localparam int REG_CTRL   = 0;
    localparam int REG_PERIOD = 1;
    localparam int REG_COUNT  = 2;
    localparam int REG_STATUS = 3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AR_BIT    = 1;
    localparam int CTRL_IE_BIT    = 2;
    localparam int STATUS_EXP_BIT = 0;

    typedef struct packed {
        logic int_en;
        logic auto_reload;
        logic enable;
    } tmr_ctrl_t;

    function automatic tmr_ctrl_t ctrl_decode(input logic [2:0] d);
        tmr_ctrl_t c;
        c.enable      = d[CTRL_EN_BIT];
        c.auto_reload = d[CTRL_AR_BIT];
        c.int_en      = d[CTRL_IE_BIT];
        return c;
    endfunction

    function automatic logic [2:0] ctrl_encode(input tmr_ctrl_t c);
        logic [2:0] d;
        d              = '0;
        d[CTRL_EN_BIT] = c.enable;
        d[CTRL_AR_BIT] = c.auto_reload;
        d[CTRL_IE_BIT] = c.int_en;
        return d;
    endfunction

endpackage

// File: rtl/hba_slave_timer_if.sv
// HBA bus signals between one master/arbiter and a responder.
interface hba_slave_timer_if #(
    parameter int DBUS_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  hba_select;
    logic                  hba_rnw;
    logic [ADDR_WIDTH-1:0] hba_abus;
    logic [DBUS_WIDTH-1:0] hba_dbus;
    logic                  hba_xferack_slave;
    logic [DBUS_WIDTH-1:0] hba_dbus_slave;
    logic                  hba_interrupt_slave;

    modport master (
        output hba_select, hba_rnw, hba_abus, hba_dbus,
        input  hba_xferack_slave, hba_dbus_slave, hba_interrupt_slave
    );

    modport slave (
        input  hba_select, hba_rnw, hba_abus, hba_dbus,
        output hba_xferack_slave, hba_dbus_slave, hba_interrupt_slave
    );
endinterface

// File: rtl/hba_slave_if.sv
// Generic HBA responder front end: slot decode, single-cycle ack, write/read strobes and
// registered read data. Reusable by any register-file responder.
module hba_slave_if
    import hba_slave_timer_pkg::*;
#(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0
) (
    input  logic                      hba_clk,
    input  logic                      rst_n,
    input  logic                      select,
    input  logic                      rnw,
    input  logic [ADDR_WIDTH-1:0]     abus,
    input  logic [DBUS_WIDTH-1:0]     rdata,
    output logic                      wr_stb,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic                      xferack,
    output logic [DBUS_WIDTH-1:0]     dbus_slave
);

    hba_state_t state, state_nxt;
    logic       hit, armed, start, rd_stb;

    assign hit      = (abus[ADDR_WIDTH-1 -: PERIPH_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
    assign reg_addr = abus[REG_ADDR_WIDTH-1:0];
    // armed needs select seen low since reset/last transfer, so a select held across reset never acks
    assign start    = (state == ST_IDLE) && select && hit && armed;

    always_ff @(posedge hba_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:          if (start) state_nxt = ST_ACK;
            ST_ACK:           state_nxt = ST_WAIT_DESELECT;
            ST_WAIT_DESELECT: if (!select) state_nxt = ST_IDLE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        xferack = (state == ST_ACK);
        wr_stb  = start && !rnw;
        rd_stb  = start && rnw;
    end

    always_ff @(posedge hba_clk or negedge rst_n) begin
        if (!rst_n)      armed <= 1'b0;
        else if (start)  armed <= 1'b0;
        else if (!select) armed <= 1'b1;
    end

    // Data is only non-zero in the ACK cycle because rd_stb can fire only on entry to ACK.
    always_ff @(posedge hba_clk or negedge rst_n) begin
        if (!rst_n) dbus_slave <= '0;
        else        dbus_slave <= rd_stb ? rdata : '0;
    end

endmodule

// File: rtl/hba_slave_timer.sv
// HBA down-counting timer responder: CTRL/PERIOD/COUNT/STATUS registers with optional
// auto-reload and a registered level interrupt.
module hba_slave_timer
    import hba_slave_timer_pkg::*;
#(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0
) (
    input logic               hba_clk,
    input logic               hba_reset_n,
    hba_slave_timer_if.slave  bus
);

    localparam int DW  = DBUS_WIDTH;
    localparam int RAW = REG_ADDR_WIDTH;

    logic [1:0]     rst_sync;
    logic           rst_n;
    logic           wr_stb;
    logic [RAW-1:0] reg_addr;
    logic [DW-1:0]  rdata;
    logic           wr_ctrl, wr_period, wr_status, fire;

    tmr_ctrl_t      ctrl_q;
    logic [DW-1:0]  period;
    logic [DW-1:0]  count;
    logic           expired;
    logic           irq;

    // Assert asynchronously, release on the clock so no flop sees a runt deassertion.
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) rst_sync <= '0;
        else              rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    hba_slave_if #(
        .DBUS_WIDTH        (DBUS_WIDTH),
        .PERIPH_ADDR_WIDTH (PERIPH_ADDR_WIDTH),
        .REG_ADDR_WIDTH    (REG_ADDR_WIDTH),
        .ADDR_WIDTH        (ADDR_WIDTH),
        .PERIPH_ADDR       (PERIPH_ADDR)
    ) u_slave_if (
        .hba_clk    (hba_clk),
        .rst_n      (rst_n),
        .select     (bus.hba_select),
        .rnw        (bus.hba_rnw),
        .abus       (bus.hba_abus),
        .rdata      (rdata),
        .wr_stb     (wr_stb),
        .reg_addr   (reg_addr),
        .xferack    (bus.hba_xferack_slave),
        .dbus_slave (bus.hba_dbus_slave)
    );

    assign wr_ctrl   = wr_stb && (reg_addr == RAW'(REG_CTRL));
    assign wr_period = wr_stb && (reg_addr == RAW'(REG_PERIOD));
    assign wr_status = wr_stb && (reg_addr == RAW'(REG_STATUS));
    assign fire      = ctrl_q.enable && (count == '0);

    // A CTRL write beats the one-shot auto-clear of enable in the same cycle.
    always_ff @(posedge hba_clk or negedge rst_n) begin
        if (!rst_n)                            ctrl_q        <= '0;
        else if (wr_ctrl)                      ctrl_q        <= ctrl_decode(bus.hba_dbus[2:0]);
        else if (fire && !ctrl_q.auto_reload)  ctrl_q.enable <= 1'b0;
    end

    always_ff @(posedge hba_clk or negedge rst_n) begin
        if (!rst_n)         period <= '0;
        else if (wr_period) period <= bus.hba_dbus;
    end

    always_ff @(posedge hba_clk or negedge rst_n) begin
        if (!rst_n)              count <= '0;
        else if (wr_period)      count <= bus.hba_dbus;
        else if (fire)           count <= ctrl_q.auto_reload ? period : '0;
        else if (ctrl_q.enable)  count <= count - DW'(1);
    end

    // Expiry set wins over a coincident write-1-to-clear.
    always_ff @(posedge hba_clk or negedge rst_n) begin
        if (!rst_n)                                          expired <= 1'b0;
        else if (fire)                                       expired <= 1'b1;
        else if (wr_status && bus.hba_dbus[STATUS_EXP_BIT])  expired <= 1'b0;
    end

    always_ff @(posedge hba_clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= expired && ctrl_q.int_en;
    end
    assign bus.hba_interrupt_slave = irq;

    // Read mux sees pre-update register values, so COUNT returns the value before this cycle's tick.
    always_comb begin
        rdata = '0;
        case (reg_addr)
            RAW'(REG_CTRL):   rdata[2:0]           = ctrl_encode(ctrl_q);
            RAW'(REG_PERIOD): rdata                = period;
            RAW'(REG_COUNT):  rdata                = count;
            RAW'(REG_STATUS): rdata[STATUS_EXP_BIT] = expired;
            default:          rdata                = '0;
        endcase
    end

endmodule

// File: tb/tb_hba_slave_timer.sv
// Bench for hba_slave_timer: vector table, directed timer/bus corner sequences and random
// bus traffic checked cycle by cycle against a register-level timer model.
module tb_hba_slave_timer;
    localparam int DW  = 8;
    localparam int PAW = 4;
    localparam int RAW = 8;
    localparam int AW  = PAW + RAW;
    localparam int PA  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hba_slave_timer_if #(.DBUS_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    hba_slave_timer #(
        .DBUS_WIDTH(DW), .PERIPH_ADDR_WIDTH(PAW), .REG_ADDR_WIDTH(RAW),
        .ADDR_WIDTH(AW), .PERIPH_ADDR(PA)
    ) dut (
        .hba_clk     (clk),
        .hba_reset_n (rst_n),
        .bus         (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Register-level model of the timer.
    int m_en, m_ar, m_ie, m_period, m_count, m_exp, m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_period = 0; m_count = 0; m_exp = 0; m_irq = 0;
    endfunction

    function automatic int model_read(input int idx);
        case (idx)
            0:       return m_en | (m_ar << 1) | (m_ie << 2);
            1:       return m_period;
            2:       return m_count;
            3:       return m_exp;
            default: return 0;
        endcase
    endfunction

    function automatic void model_step(input bit wr, input int idx, input int wd);
        int fired, nirq;
        nirq  = (m_exp != 0 && m_ie != 0) ? 1 : 0;
        fired = (m_en != 0 && m_count == 0) ? 1 : 0;
        if (m_en != 0) begin
            if (fired != 0) begin
                m_exp = 1;
                if (m_ar != 0) m_count = m_period;
                else           m_en = 0;
            end else begin
                m_count = m_count - 1;
            end
        end
        if (wr) begin
            case (idx)
                0: begin m_en = wd & 1; m_ar = (wd >> 1) & 1; m_ie = (wd >> 2) & 1; end
                1: begin m_period = wd; m_count = wd; end
                3: if ((wd & 1) != 0 && fired == 0) m_exp = 0;
                default: ;
            endcase
        end
        m_irq = nirq;
    endfunction

    task automatic drive(input bit sel, input bit rnw, input int slot, input int idx, input int d);
        bus.hba_select = sel;
        bus.hba_rnw    = rnw;
        bus.hba_abus   = {PAW'(slot), RAW'(idx)};
        bus.hba_dbus   = DW'(d);
    endtask

    // One clock: model advances with the edge, then every visible output is compared.
    task automatic tick(input bit start);
        bit rnw;
        int idx, wd, exp_rd;
        rnw    = bus.hba_rnw;
        idx    = int'(bus.hba_abus[RAW-1:0]);
        wd     = int'(bus.hba_dbus);
        exp_rd = (start && rnw) ? model_read(idx) : 0;
        @(posedge clk);
        model_step(start && !rnw, idx, wd);
        #1;
        check("xferack", bus.hba_xferack_slave, start);
        check("dbus_slave", bus.hba_dbus_slave, exp_rd);
        check("interrupt", bus.hba_interrupt_slave, m_irq);
        check("count", dut.count, m_count);
        check("expired", dut.expired, m_exp);
        @(negedge clk);
    endtask

    task automatic xfer(input bit rnw, input int slot, input int idx, input int d,
                        input int hold, input int gap, output int acks, output int rd);
        acks = 0;
        rd   = 0;
        for (int c = 0; c < hold + gap; c++) begin
            drive(c < hold, rnw, slot, idx, d);
            tick(c == 0 && slot == PA);
            if (bus.hba_xferack_slave === 1'b1) begin
                acks++;
                rd = int'(bus.hba_dbus_slave);
            end
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick(0);
    endtask

    typedef struct {
        bit rnw;
        int slot;
        int idx;
        int d;
        int exp_ack;
        int exp_rd;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int acks, rd;
        drive(0, 0, 0, 0, 0);

        tbl[0]  = '{1'b0, PA,     1, 8'h2A, 1, 8'h00};
        tbl[1]  = '{1'b1, PA,     1, 0,     1, 8'h2A};
        tbl[2]  = '{1'b1, PA,     2, 0,     1, 8'h2A};
        tbl[3]  = '{1'b0, PA,     2, 8'h11, 1, 8'h00};
        tbl[4]  = '{1'b1, PA,     2, 0,     1, 8'h2A};
        tbl[5]  = '{1'b1, PA,     7, 0,     1, 8'h00};
        tbl[6]  = '{1'b0, PA,     0, 8'h06, 1, 8'h00};
        tbl[7]  = '{1'b1, PA,     0, 0,     1, 8'h06};
        tbl[8]  = '{1'b1, PA,     3, 0,     1, 8'h00};
        tbl[9]  = '{1'b1, PA + 1, 1, 0,     0, 8'h00};
        tbl[10] = '{1'b0, PA + 1, 1, 8'h55, 0, 8'h00};
        tbl[11] = '{1'b1, PA,     1, 0,     1, 8'h2A};
        tbl[12] = '{1'b0, PA,     0, 8'h00, 1, 8'h00};
        tbl[13] = '{1'b1, PA,     4, 0,     1, 8'h00};

        do_reset();
        check("reset_ack", bus.hba_xferack_slave, 0);
        check("reset_irq", bus.hba_interrupt_slave, 0);

        for (int i = 0; i < 14; i++) begin
            xfer(tbl[i].rnw, tbl[i].slot, tbl[i].idx, tbl[i].d, 1, 2, acks, rd);
            check($sformatf("vec%0d_ack", i), acks, tbl[i].exp_ack);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end

        // One-shot: PERIOD=5 then enable -> 5..0, expiry six cycles after enable.
        do_reset();
        xfer(0, PA, 1, 5, 1, 2, acks, rd);
        drive(1, 0, PA, 0, 1);
        tick(1);
        check("oneshot_count5", dut.count, 5);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, PA, 0, 0);
            tick(0);
            check($sformatf("oneshot_count%0d", 5 - k), dut.count, 5 - k);
            check("oneshot_not_expired", dut.expired, 0);
        end
        tick(0);
        check("oneshot_expired", dut.expired, 1);
        check("oneshot_enable_clr", dut.ctrl_q.enable, 0);
        xfer(1, PA, 0, 0, 1, 2, acks, rd);
        check("oneshot_ctrl_rd", rd, 0);
        xfer(1, PA, 2, 0, 1, 2, acks, rd);
        check("oneshot_count_rd", rd, 0);

        // Auto-reload PERIOD=3 with interrupt; W1C, then W1C on an expiry edge.
        do_reset();
        xfer(0, PA, 1, 3, 1, 2, acks, rd);
        xfer(0, PA, 0, 7, 1, 2, acks, rd);
        drive(0, 0, PA, 0, 0);
        tick(0);
        check("reload_count0", dut.count, 0);
        tick(0);
        check("reload_count3", dut.count, 3);
        check("reload_expired", dut.expired, 1);
        tick(0);
        tick(0);
        check("reload_irq", bus.hba_interrupt_slave, 1);
        drive(1, 0, PA, 3, 1);
        tick(1);
        check("irq_before_clear", bus.hba_interrupt_slave, 1);
        drive(0, 0, PA, 3, 0);
        tick(0);
        check("irq_cleared", bus.hba_interrupt_slave, 0);
        repeat (3) tick(0);
        drive(1, 0, PA, 3, 1);
        tick(1);
        check("w1c_on_expiry", dut.expired, 1);
        drive(0, 0, PA, 0, 0);
        tick(0);
        tick(0);

        // Long select: one ack only, then wrong slot and unmapped register.
        xfer(1, PA, 1, 0, 10, 2, acks, rd);
        check("long_sel_acks", acks, 1);
        check("long_sel_rdata", rd, 3);
        xfer(1, PA + 1, 1, 0, 1, 2, acks, rd);
        check("other_slot_acks", acks, 0);
        check("other_slot_rdata", rd, 0);
        xfer(1, PA, 7, 0, 1, 2, acks, rd);
        check("unmapped_acks", acks, 1);
        check("unmapped_rdata", rd, 0);

        // Reset during ACK with select held across release.
        drive(1, 0, PA, 1, 8'h44);
        tick(1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_ack_drop", bus.hba_xferack_slave, 0);
        check("rst_count", dut.count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick(0);
        drive(0, 0, PA, 0, 0);
        tick(0);
        tick(0);
        for (int r = 0; r < 4; r++) begin
            xfer(1, PA, r, 0, 1, 2, acks, rd);
            check($sformatf("post_rst_ack_r%0d", r), acks, 1);
            check($sformatf("post_rst_rd_r%0d", r), rd, 0);
        end

        // Random traffic against the model.
        do_reset();
        for (int t = 0; t < 150; t++) begin
            int slot, idx, d, hold, gap, sel;
            bit rnw;
            slot = ($urandom_range(0, 9) == 0) ? PA + 1 : PA;
            rnw  = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 9);
            idx  = (sel < 8) ? sel % 4 : $urandom_range(4, 255);
            d    = (idx == 1) ? $urandom_range(0, 6) : $urandom_range(0, 255);
            hold = $urandom_range(1, 3);
            gap  = $urandom_range((hold == 1) ? 2 : 1, 3);
            xfer(rnw, slot, idx, d, hold, gap, acks, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
